string_capture: RTL and testbench

STRING_CAPTURE -- requirements
Module: string_capture

---
 rtl/string_capture.sv | 85 ++++++++
 tb/tb_string_capture.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/string_capture.sv
// Serial-to-parallel frame capture: shifts WIDTH bits in MSB first, then holds the
// frame until the consumer acknowledges it. Shifts arriving while full raise Overrun.
module string_capture #(
  parameter int unsigned WIDTH = 77
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       Start,
  input  logic                       SerIn,
  input  logic                       Shift,
  input  logic                       Ack,
  output logic [WIDTH-1:0]           String,
  output logic [$clog2(WIDTH+1)-1:0] Count,
  output logic                       Busy,
  output logic                       Ready,
  output logic                       Overrun
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StFull} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  string_q, string_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              overrun_q, overrun_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      string_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      string_q  <= string_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    string_d  = string_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    // Start wins over any coincident Shift or Ack, in every state.
    if (Start) begin
      state_d   = StCollect;
      string_d  = '0;
      count_d   = '0;
      overrun_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StCollect: begin
          if (Shift) begin
            string_d = {string_q[WIDTH-2:0], SerIn};
            count_d  = count_q + 1'b1;
            if (count_q == LastIdx) begin
              state_d = StFull;
            end
          end
        end
        StFull: begin
          if (Shift) begin
            overrun_d = 1'b1;
          end
          if (Ack) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign String  = string_q;
  assign Count   = count_q;
  assign Overrun = overrun_q;
  assign Busy    = (state_q == StCollect);
  assign Ready   = (state_q == StFull);

endmodule

// File: tb/tb_string_capture.sv
// Self-checking bench for string_capture: randomized bit streams compared against a
// frame model built from the list of bits sent.
module tb_string_capture;

  localparam int W = 77;

  logic          clk, rst, Start, SerIn, Shift, Ack;
  logic [W-1:0]  String;
  logic [6:0]    Count;
  logic          Busy, Ready, Overrun;

  int errors = 0;
  int checks = 0;

  bit sent[W];

  string_capture #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .Start  (Start),
    .SerIn  (SerIn),
    .Shift  (Shift),
    .Ack    (Ack),
    .String (String),
    .Count  (Count),
    .Busy   (Busy),
    .Ready  (Ready),
    .Overrun(Overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // First of n bits sent lands at position n-1, last at position 0.
  function automatic logic [W-1:0] frame_of(input int n);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[n-1-i] = sent[i];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  task automatic do_shift(input logic b);
    Shift = 1'b1;
    SerIn = b;
    step();
    Shift = 1'b0;
  endtask

  task automatic fill_random();
    pulse_start();
    for (int i = 0; i < W; i++) begin
      sent[i] = 1'($urandom_range(0, 1));
      do_shift(sent[i]);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (String !== '0 || Count !== 7'd0 || Busy !== 1'b0 || Ready !== 1'b0 ||
        Overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: String=%h Count=%0d Busy=%b Ready=%b Overrun=%b, want all 0",
               String, Count, Busy, Ready, Overrun);
    end
    Shift = 1'b1;
    SerIn = 1'b1;
    repeat (3) step();
    Shift = 1'b0;
    checks++;
    if (Count !== 7'd0 || Busy !== 1'b0 || String !== '0) begin
      errors++;
      $display("FAIL idle_shift_ignored: Count=%0d Busy=%b String=%h, want 0 0 0",
               Count, Busy, String);
    end
  endtask

  task automatic test_alternating();
    logic [W-1:0] want;
    want = {1'b1, {19{4'h5}}};
    pulse_start();
    checks++;
    if (Busy !== 1'b1 || Count !== 7'd0) begin
      errors++;
      $display("FAIL alt_armed: Busy=%b Count=%0d, want 1 0", Busy, Count);
    end
    for (int i = 0; i < W; i++) begin
      sent[i] = (i % 2 == 0);
      if (i == W - 1) begin
        checks++;
        if (Ready !== 1'b0 || Count !== 7'd76) begin
          errors++;
          $display("FAIL alt_before_last: Ready=%b Count=%0d, want 0 76", Ready, Count);
        end
      end
      do_shift(sent[i]);
    end
    checks++;
    if (Ready !== 1'b1 || Busy !== 1'b0 || Count !== 7'd77) begin
      errors++;
      $display("FAIL alt_full: Ready=%b Busy=%b Count=%0d, want 1 0 77", Ready, Busy, Count);
    end
    checks++;
    if (String !== want || String !== frame_of(W)) begin
      errors++;
      $display("FAIL alt_string: got %h want %h", String, want);
    end
    Ack = 1'b1;
    step();
    Ack = 1'b0;
  endtask

  task automatic test_random_gaps();
    int gap;
    pulse_start();
    for (int i = 0; i < W; i++) begin
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) begin
        SerIn = 1'($urandom_range(0, 1));
        Ack   = 1'($urandom_range(0, 1));
        step();
        checks++;
        if (Count !== 7'(i) || Busy !== 1'b1 || String !== frame_of(i)) begin
          errors++;
          $display("FAIL gap_hold: bit %0d Count=%0d Busy=%b String=%h want %0d 1 %h",
                   i, Count, Busy, String, i, frame_of(i));
        end
      end
      Ack = 1'b0;
      sent[i] = 1'($urandom_range(0, 1));
      do_shift(sent[i]);
      checks++;
      if (Count !== 7'(i + 1)) begin
        errors++;
        $display("FAIL gap_count: got %0d want %0d", Count, i + 1);
      end
    end
    checks++;
    if (String !== frame_of(W) || Ready !== 1'b1 || Overrun !== 1'b0) begin
      errors++;
      $display("FAIL gap_frame: String=%h Ready=%b Overrun=%b want %h 1 0",
               String, Ready, Overrun, frame_of(W));
    end
  endtask

  // Continues from the FULL state left by test_random_gaps.
  task automatic test_overrun_ack();
    logic [W-1:0] held;
    held = frame_of(W);
    do_shift(1'b1);
    checks++;
    if (Overrun !== 1'b1 || String !== held || Count !== 7'd77 || Ready !== 1'b1) begin
      errors++;
      $display("FAIL overrun: Overrun=%b String=%h Count=%0d Ready=%b want 1 %h 77 1",
               Overrun, String, Count, Ready, held);
    end
    Ack = 1'b1;
    step();
    Ack = 1'b0;
    checks++;
    if (Ready !== 1'b0 || Busy !== 1'b0 || String !== held || Overrun !== 1'b1) begin
      errors++;
      $display("FAIL ack_release: Ready=%b Busy=%b String=%h Overrun=%b want 0 0 %h 1",
               Ready, Busy, String, Overrun, held);
    end
    do_shift(1'b0);
    checks++;
    if (String !== held || Busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: String=%h Busy=%b want %h 0", String, Busy, held);
    end
  endtask

  task automatic test_start_priority();
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      sent[i] = 1'($urandom_range(0, 1));
      do_shift(sent[i]);
    end
    checks++;
    if (Count !== 7'd40 || String !== frame_of(40)) begin
      errors++;
      $display("FAIL partial40: Count=%0d String=%h want 40 %h", Count, String, frame_of(40));
    end
    Start = 1'b1;
    Shift = 1'b1;
    SerIn = 1'b1;
    step();
    Start = 1'b0;
    Shift = 1'b0;
    checks++;
    if (Count !== 7'd0 || String !== '0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL start_over_shift: Count=%0d String=%h Busy=%b want 0 0 1",
               Count, String, Busy);
    end
  endtask

  task automatic test_async_reset();
    pulse_start();
    for (int i = 0; i < 10; i++) do_shift(1'b1);
    checks++;
    if (Count !== 7'd10) begin
      errors++;
      $display("FAIL pre_reset_count: got %0d want 10", Count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (String !== '0 || Count !== 7'd0 || Busy !== 1'b0 || Ready !== 1'b0 ||
        Overrun !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: String=%h Count=%0d Busy=%b Ready=%b Overrun=%b want 0",
               String, Count, Busy, Ready, Overrun);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) do_shift(1'b1);
    checks++;
    if (Count !== 7'd0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_shift: Count=%0d Busy=%b want 0 0", Count, Busy);
    end
  endtask

  task automatic test_start_ack_full();
    fill_random();
    do_shift(1'b1);
    checks++;
    if (Ready !== 1'b1 || Overrun !== 1'b1 || String !== frame_of(W)) begin
      errors++;
      $display("FAIL refill: Ready=%b Overrun=%b String=%h want 1 1 %h",
               Ready, Overrun, String, frame_of(W));
    end
    Start = 1'b1;
    Ack   = 1'b1;
    step();
    Start = 1'b0;
    Ack   = 1'b0;
    checks++;
    if (Busy !== 1'b1 || Ready !== 1'b0 || Count !== 7'd0 || Overrun !== 1'b0 ||
        String !== '0) begin
      errors++;
      $display("FAIL start_ack_full: Busy=%b Ready=%b Count=%0d Overrun=%b String=%h want 1 0 0 0 0",
               Busy, Ready, Count, Overrun, String);
    end
  endtask

  initial begin
    rst   = 1'b1;
    Start = 1'b0;
    SerIn = 1'b0;
    Shift = 1'b0;
    Ack   = 1'b0;
    #23 rst = 1'b0;
    step();
    test_reset();
    test_alternating();
    test_random_gaps();
    test_overrun_ack();
    test_start_priority();
    test_async_reset();
    test_start_ack_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
